wb_dma_rd: RTL and testbench

WB_DMA_RD -- requirements
Module: wb_dma_rd

---
 rtl/wb_dma_pkg.sv | 27 ++
 rtl/wb_dma_fifo.sv | 75 +++++++
 rtl/wb_dma_rd.sv | 190 +++++++++++++++++++
 tb/tb_wb_dma_rd.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_dma_pkg.sv
// Shared types and constants for the Wishbone DMA read engine.
// Holds the FSM state encoding, page geometry, backoff length and default parameters.
package wb_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_BURST,
        ST_BACKOFF,
        ST_DONE,
        ST_ERROR
    } dma_state_t;

    localparam int unsigned PAGE_BYTES     = 4096;
    localparam int unsigned PAGE_WORDS     = PAGE_BYTES / 4;
    localparam int unsigned BACKOFF_CYCLES = 4;

    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_MAX_BURST  = 8;
    localparam int DEF_RTY_LIMIT  = 15;

    // Words left before the next 4 KB page boundary for a given word address.
    function automatic logic [15:0] words_to_page(input logic [29:0] word_adr);
        return 16'(PAGE_WORDS) - 16'(word_adr[9:0]);
    endfunction

endpackage

// File: rtl/wb_dma_fifo.sv
// Synchronous read-data FIFO with a registered head word.
// The head register is loaded directly on a push into an empty FIFO, otherwise from storage.
module wb_dma_fifo
    import wb_dma_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             head_valid_reg;
    logic [WIDTH-1:0] head_data_reg;

    logic pop_ok, mem_empty, head_from_mem, head_from_push, mem_wr;

    always_comb begin
        pop_ok         = pop && head_valid_reg;
        mem_empty      = (count_reg == CW'(head_valid_reg));
        head_from_mem  = pop_ok && !mem_empty;
        head_from_push = push && (!head_valid_reg || (pop_ok && mem_empty));
        mem_wr         = push && !head_from_push;
    end

    // Storage behind the head has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            head_valid_reg <= 1'b0;
            head_data_reg  <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (head_from_mem) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(push) - CW'(pop_ok);
            if (head_from_mem) begin
                head_data_reg  <= mem[rd_ptr_reg];
                head_valid_reg <= 1'b1;
            end else if (head_from_push) begin
                head_data_reg  <= push_data;
                head_valid_reg <= 1'b1;
            end else if (pop_ok) begin
                head_valid_reg <= 1'b0;
            end
        end
    end

    assign head_valid = head_valid_reg;
    assign head_data  = head_data_reg;
    assign count      = count_reg;

endmodule

// File: rtl/wb_dma_rd.sv
// Wishbone read DMA engine: splits a command into page-safe bursts, retries with
// backoff, and streams the returned words through a FIFO to the consumer.
module wb_dma_rd
    import wb_dma_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int RTY_LIMIT  = DEF_RTY_LIMIT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_adr,
    input  logic [15:0] cmd_len,
    output logic [31:0] wbm_adr_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_cab_o,
    output logic        wbm_pref_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_rty_i,
    input  logic        wbm_err_i,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [31:0] dout_data,
    output logic        done_o,
    output logic        err_o,
    output logic        int_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = $clog2(RTY_LIMIT + 1) + 1;
    localparam int BW = $clog2(BACKOFF_CYCLES + 1);

    dma_state_t     state_reg;
    logic [29:0]    adr_reg;
    logic [15:0]    remaining_reg;
    logic [15:0]    burst_reg;
    logic [RW-1:0]  rty_cnt_reg;
    logic [BW-1:0]  backoff_cnt_reg;
    logic           cyc_reg, cab_reg, done_reg, err_reg, int_reg;

    logic [CW-1:0]  fifo_count, fifo_free;
    logic [15:0]    page_room, blen_calc;
    logic           term_err, term_ack, term_rty;
    logic           unused_adr_lsb;

    assign unused_adr_lsb = &{1'b0, cmd_adr[1:0]};

    // Next burst length: bounded by remaining words, MAX_BURST and the page edge.
    always_comb begin
        page_room = words_to_page(adr_reg);
        blen_calc = remaining_reg;
        if (blen_calc > 16'(MAX_BURST)) begin
            blen_calc = 16'(MAX_BURST);
        end
        if (blen_calc > page_room) begin
            blen_calc = page_room;
        end
        fifo_free = CW'(FIFO_DEPTH) - fifo_count;
    end

    assign term_err = cyc_reg && wbm_err_i;
    assign term_ack = cyc_reg && wbm_ack_i && !wbm_err_i;
    assign term_rty = cyc_reg && wbm_rty_i && !wbm_ack_i && !wbm_err_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg       <= ST_IDLE;
            adr_reg         <= '0;
            remaining_reg   <= '0;
            burst_reg       <= '0;
            rty_cnt_reg     <= '0;
            backoff_cnt_reg <= '0;
            cyc_reg         <= 1'b0;
            cab_reg         <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
            int_reg         <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            int_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        adr_reg       <= cmd_adr[31:2];
                        remaining_reg <= cmd_len;
                        rty_cnt_reg   <= '0;
                        err_reg       <= 1'b0;
                        if (cmd_len == 16'd0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            int_reg   <= 1'b1;
                        end else begin
                            state_reg <= ST_ARB;
                        end
                    end
                end
                ST_ARB: begin
                    // Reserve the whole burst up front so acks can never overflow the FIFO.
                    if (32'(fifo_free) >= 32'(blen_calc)) begin
                        burst_reg <= blen_calc;
                        cab_reg   <= (blen_calc > 16'd1);
                        cyc_reg   <= 1'b1;
                        state_reg <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (term_err) begin
                        cyc_reg   <= 1'b0;
                        cab_reg   <= 1'b0;
                        err_reg   <= 1'b1;
                        int_reg   <= 1'b1;
                        state_reg <= ST_ERROR;
                    end else if (term_ack) begin
                        adr_reg       <= adr_reg + 30'd1;
                        remaining_reg <= remaining_reg - 16'd1;
                        burst_reg     <= burst_reg - 16'd1;
                        rty_cnt_reg   <= '0;
                        if (burst_reg == 16'd1) begin
                            cyc_reg <= 1'b0;
                            cab_reg <= 1'b0;
                            if (remaining_reg == 16'd1) begin
                                done_reg  <= 1'b1;
                                int_reg   <= 1'b1;
                                state_reg <= ST_DONE;
                            end else begin
                                state_reg <= ST_ARB;
                            end
                        end
                    end else if (term_rty) begin
                        // Address and remaining count are untouched so the burst resumes here.
                        cyc_reg <= 1'b0;
                        cab_reg <= 1'b0;
                        if (rty_cnt_reg == RW'(RTY_LIMIT)) begin
                            err_reg   <= 1'b1;
                            int_reg   <= 1'b1;
                            state_reg <= ST_ERROR;
                        end else begin
                            rty_cnt_reg     <= rty_cnt_reg + 1'b1;
                            backoff_cnt_reg <= BW'(BACKOFF_CYCLES - 1);
                            state_reg       <= ST_BACKOFF;
                        end
                    end
                end
                ST_BACKOFF: begin
                    if (backoff_cnt_reg == '0) begin
                        state_reg <= ST_ARB;
                    end else begin
                        backoff_cnt_reg <= backoff_cnt_reg - 1'b1;
                    end
                end
                ST_DONE:  state_reg <= ST_IDLE;
                ST_ERROR: state_reg <= ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    wb_dma_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32),
        .CW    (CW)
    ) u_fifo (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .push       (term_ack),
        .push_data  (wbm_dat_i),
        .pop        (dout_ready),
        .head_valid (dout_valid),
        .head_data  (dout_data),
        .count      (fifo_count)
    );

    assign cmd_ready  = (state_reg == ST_IDLE);
    assign wbm_adr_o  = {adr_reg, 2'b00};
    assign wbm_sel_o  = 4'hF;
    assign wbm_we_o   = 1'b0;
    assign wbm_cyc_o  = cyc_reg;
    assign wbm_stb_o  = cyc_reg;
    assign wbm_cab_o  = cab_reg;
    assign wbm_pref_o = cab_reg;
    assign done_o     = done_reg;
    assign err_o      = err_reg;
    assign int_o      = int_reg;

endmodule

// File: tb/tb_wb_dma_rd.sv
// Directed bench for wb_dma_rd: a Wishbone slave model, a burst/data model
// derived from the transfer rules, and a per-cycle monitor that checks against it.
module tb_wb_dma_rd;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_adr = '0;
    logic [15:0] cmd_len = '0;
    logic [31:0] wbm_adr_o, wbm_dat_i, dout_data;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cab_o, wbm_pref_o;
    logic        wbm_ack_i, wbm_rty_i, wbm_err_i;
    logic        dout_valid, done_o, err_o, int_o;
    logic        dout_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_dma_rd dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_adr    (cmd_adr),
        .cmd_len    (cmd_len),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_cab_o  (wbm_cab_o),
        .wbm_pref_o (wbm_pref_o),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_rty_i  (wbm_rty_i),
        .wbm_err_i  (wbm_err_i),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .done_o     (done_o),
        .err_o      (err_o),
        .int_o      (int_o)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int  cycle = 0;
    int  total_acks = 0, total_rty = 0;
    int  ack_base = 0, rty_base = 0;
    int  rty_word = 0, rty_budget = 0, err_word = 0;
    bit  err_en = 1'b0;

    assign wbm_err_i = wbm_cyc_o && err_en && ((total_acks - ack_base) == err_word);
    assign wbm_rty_i = wbm_cyc_o && ((total_rty - rty_base) < rty_budget) && ((total_acks - ack_base) == rty_word);
    assign wbm_ack_i = wbm_cyc_o && !wbm_rty_i;
    assign wbm_dat_i = word_of(wbm_adr_o);

    initial begin
        forever begin
            @(posedge wb_clk_i);
            cycle = cycle + 1;
            if (!wb_rst_i && wbm_cyc_o) begin
                if (!wbm_err_i && wbm_ack_i) total_acks <= total_acks + 1;
                else if (!wbm_err_i && wbm_rty_i) total_rty <= total_rty + 1;
            end
        end
    end

    // ---------------- transfer model ----------------
    logic [31:0] exp_start[$];
    int          exp_len[$];
    logic [31:0] exp_data_q[$];

    function automatic void model_cmd(input logic [31:0] adr, input int len);
        logic [31:0] a;
        int rem, to_page, n;
        a = {adr[31:2], 2'b00};
        rem = len;
        exp_start.delete();
        exp_len.delete();
        while (rem > 0) begin
            to_page = (4096 - int'(a % 4096)) / 4;
            n = rem;
            if (n > 8) n = 8;
            if (n > to_page) n = to_page;
            exp_start.push_back(a);
            exp_len.push_back(n);
            a = a + 32'(4 * n);
            rem = rem - n;
        end
        for (int i = 0; i < len; i++) exp_data_q.push_back(word_of({adr[31:2], 2'b00} + 32'(4 * i)));
    endfunction

    // ---------------- monitor ----------------
    logic [31:0] obs_start[$];
    int          obs_acks[$], obs_kind[$], obs_gap[$];
    bit          obs_cab[$];
    int          done_cnt = 0, int_cnt = 0, err_rise = 0;
    int          acc_cycle = 0, first_stb = -1, occ = 0;

    initial begin
        bit          prev_cyc, prev_push, prev_err, push, pop, cur_cab;
        logic [31:0] cur_start;
        int          cur_acks, cur_kind, low_cnt;
        prev_cyc = 0; prev_push = 0; prev_err = 0; cur_cab = 0;
        cur_start = '0; cur_acks = 0; cur_kind = 3; low_cnt = 0;
        forever begin
            @(negedge wb_clk_i);
            if (wb_rst_i) begin
                prev_cyc = 0; prev_push = 0; prev_err = 0; occ = 0; low_cnt = 0;
            end else begin
                push = wbm_cyc_o && wbm_ack_i && !wbm_err_i;
                pop  = dout_valid && dout_ready;
                if (cmd_valid && cmd_ready) begin
                    acc_cycle = cycle;
                    first_stb = -1;
                end
                if (prev_push) check("rd_latency", 64'(dout_valid), 64'd1);
                if (wbm_cyc_o && !prev_cyc) begin
                    cur_start = wbm_adr_o; cur_cab = wbm_cab_o; cur_acks = 0; cur_kind = 3;
                    obs_gap.push_back(low_cnt);
                    if (first_stb < 0) first_stb = cycle;
                end
                if (wbm_cyc_o) begin
                    check("bus_qual", 64'({wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_pref_o}),
                          64'({1'b1, 1'b0, 4'hF, cur_cab}));
                    check("cab_stable", 64'(wbm_cab_o), 64'(cur_cab));
                    check("page_cross", 64'(wbm_adr_o[31:12]), 64'(cur_start[31:12]));
                    if (wbm_err_i) cur_kind = 2;
                    else if (wbm_ack_i) begin cur_acks++; cur_kind = 0; end
                    else if (wbm_rty_i) cur_kind = 1;
                end
                if (!wbm_cyc_o && prev_cyc) begin
                    obs_start.push_back(cur_start);
                    obs_acks.push_back(cur_acks);
                    obs_kind.push_back(cur_kind);
                    obs_cab.push_back(cur_cab);
                end
                low_cnt = wbm_cyc_o ? 0 : low_cnt + 1;
                if (pop) begin
                    if (exp_data_q.size() == 0) check("pop_extra", 64'(dout_data), 64'hFFFF_FFFF_FFFF_FFFF);
                    else check("dout_data", 64'(dout_data), 64'(exp_data_q.pop_front()));
                end
                occ = occ + int'(push) - int'(pop);
                check("fifo_bound", 64'(occ <= 16), 64'd1);
                if (done_o) done_cnt++;
                if (int_o) int_cnt++;
                if (err_o && !prev_err) err_rise++;
                prev_cyc = wbm_cyc_o; prev_push = push; prev_err = err_o;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic start_cmd(input logic [31:0] adr, input int len);
        int n;
        ack_base = total_acks; rty_base = total_rty;
        obs_start.delete(); obs_acks.delete(); obs_kind.delete(); obs_cab.delete(); obs_gap.delete();
        done_cnt = 0; int_cnt = 0; err_rise = 0;
        n = 0;
        while (!cmd_ready && n < 200) begin step(1); n++; end
        if (!cmd_ready) check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_adr = adr; cmd_len = 16'(len); cmd_valid = 1'b1;
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && err_rise == 0 && n < budget) begin step(1); n++; end
        if (n >= budget) check({tag, "_timeout"}, 64'd0, 64'd1);
        n = 0;
        while (dout_ready && exp_data_q.size() != 0 && n < 100) begin step(1); n++; end
        step(3);
    endtask

    task automatic cmp_bursts(input string tag);
        check({tag, "_nbursts"}, 64'(obs_start.size()), 64'(exp_start.size()));
        for (int i = 0; i < exp_start.size() && i < obs_start.size(); i++) begin
            check({tag, "_start"}, 64'(obs_start[i]), 64'(exp_start[i]));
            check({tag, "_len"}, 64'(obs_acks[i]), 64'(exp_len[i]));
            check({tag, "_cab"}, 64'(obs_cab[i]), 64'(exp_len[i] > 1));
            check({tag, "_kind"}, 64'(obs_kind[i]), 64'd0);
            check({tag, "_gap"}, 64'(obs_gap[i] >= 1), 64'd1);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        #12;
        check("rst_outputs", 64'({cmd_ready, wbm_cyc_o, wbm_stb_o, wbm_cab_o, wbm_pref_o,
                                   dout_valid, done_o, err_o, int_o}), 64'b1_0000_0000);
        check("rst_adr", 64'(wbm_adr_o), 64'd0);
        step(2);
        wb_rst_i = 1'b0;
        step(2);

        // 20 words from 0x1000: bursts 8/8/4, two-cycle command-to-strobe latency
        dout_ready = 1'b1;
        model_cmd(32'h1000, 20);
        check("model_s1", 64'({exp_start[0][15:0], exp_start[1][15:0], exp_start[2][15:0]}), 64'h1000_1020_1040);
        check("model_s1_len", 64'({8'(exp_len[0]), 8'(exp_len[1]), 8'(exp_len[2])}), 64'h080804);
        start_cmd(32'h1000, 20);
        wait_end("s1", 300);
        cmp_bursts("s1");
        check("s1_latency", 64'(first_stb - acc_cycle), 64'd2);
        check("s1_done_int", 64'({8'(done_cnt), 8'(int_cnt)}), 64'h0101);
        check("s1_drained", 64'(exp_data_q.size()), 64'd0);

        // Burst split at the 0x2000 page boundary
        model_cmd(32'h1FF8, 5);
        check("model_s2", 64'({exp_start[0][15:0], 8'(exp_len[0]), exp_start[1][15:0], 8'(exp_len[1])}),
              64'h1FF8_02_2000_03);
        start_cmd(32'h1FF8, 5);
        wait_end("s2", 200);
        cmp_bursts("s2");

        // Consumer stalled: engine parks in ARB with a full FIFO, then completes
        dout_ready = 1'b0;
        model_cmd(32'h4000, 40);
        start_cmd(32'h4000, 40);
        step(80);
        check("s3_held", 64'(occ), 64'd16);
        check("s3_bursts", 64'(obs_start.size()), 64'd2);
        check("s3_stall", 64'({cmd_ready, wbm_cyc_o, dout_valid}), 64'b001);
        dout_ready = 1'b1;
        wait_end("s3", 400);
        cmp_bursts("s3");
        check("s3_drained", 64'(exp_data_q.size()), 64'd0);

        // One retry on the 3rd word; resume at +8 after backoff (4 cycles) plus one arbitration cycle
        rty_word = 2; rty_budget = 1;
        model_cmd(32'h3000, 8);
        start_cmd(32'h3000, 8);
        wait_end("s4", 200);
        check("s4_nbursts", 64'(obs_start.size()), 64'd2);
        if (obs_start.size() == 2) begin
            check("s4_b0", 64'({obs_start[0], 8'(obs_acks[0]), 4'(obs_kind[0])}), 64'h3000_02_1);
            check("s4_b1", 64'({obs_start[1], 8'(obs_acks[1]), 4'(obs_kind[1])}), 64'h3008_06_0);
            check("s4_gap", 64'(obs_gap[1]), 64'd5);
        end
        check("s4_done", 64'(done_cnt), 64'd1);
        check("s4_drained", 64'(exp_data_q.size()), 64'd0);

        // Retry forever: 16 attempts then error
        rty_word = 0; rty_budget = 1000;
        start_cmd(32'h5000, 4);
        wait_end("s5", 400);
        check("s5_attempts", 64'(obs_start.size()), 64'd16);
        check("s5_status", 64'({err_o, 8'(int_cnt), 8'(done_cnt)}), 64'h1_01_00);
        step(5);
        check("s5_sticky", 64'(err_o), 64'd1);
        rty_budget = 0;

        // Error on the 2nd word (ack also high: err wins); first word survives
        dout_ready = 1'b0;
        err_en = 1'b1; err_word = 1;
        exp_data_q.push_back(word_of(32'h6000));
        start_cmd(32'h6000, 4);
        check("s6_err_clear", 64'(err_o), 64'd0);
        wait_end("s6", 200);
        check("s6_status", 64'({err_o, 8'(int_cnt), 8'(done_cnt), 8'(obs_acks.size() > 0 ? obs_acks[0] : 99)}),
              64'h1_01_00_01);
        check("s6_head", 64'({dout_valid, dout_data}), 64'({1'b1, word_of(32'h6000)}));
        dout_ready = 1'b1;
        step(4);
        check("s6_empty", 64'({dout_valid, 8'(exp_data_q.size())}), 64'h0_00);
        err_en = 1'b0;

        // Zero-length command: done without a bus cycle
        start_cmd(32'h7000, 0);
        wait_end("s7", 50);
        check("s7_nobus", 64'(obs_start.size() + obs_gap.size()), 64'd0);
        check("s7_done", 64'({8'(done_cnt), 8'(int_cnt)}), 64'h0101);

        // Reset in the middle of a burst
        dout_ready = 1'b0;
        model_cmd(32'h8000, 40);
        start_cmd(32'h8000, 40);
        begin
            int n;
            n = 0;
            while ((total_acks - ack_base) < 5 && n < 100) begin step(1); n++; end
            check("s8_inburst", 64'(wbm_cyc_o), 64'd1);
        end
        #3;
        wb_rst_i = 1'b1;
        #1;
        check("s8_rst_now", 64'({wbm_cyc_o, wbm_stb_o, dout_valid, cmd_ready}), 64'b0001);
        check("s8_rst_adr", 64'(wbm_adr_o), 64'd0);
        exp_data_q.delete();
        step(2);
        wb_rst_i = 1'b0;
        step(3);
        check("s8_after", 64'({wbm_cyc_o, dout_valid, cmd_ready}), 64'b001);

        // Recovery after reset
        dout_ready = 1'b1;
        model_cmd(32'h9000, 3);
        start_cmd(32'h9000, 3);
        wait_end("s9", 100);
        cmp_bursts("s9");
        check("s9_drained", 64'(exp_data_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
